// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM state type and RV32M MUL-group ctrl encodings.
package mul_pkg;
   typedef enum logic [1:0] {IDLE, CALC, FIX} mul_state_t;
   localparam logic [2:0] MUL_OP_MUL    = 3'b000;
   localparam logic [2:0] MUL_OP_MULH   = 3'b001;
   localparam logic [2:0] MUL_OP_MULHSU = 3'b010;
   localparam logic [2:0] MUL_OP_MULHU  = 3'b011;
   // ctrl[2] selects the divider in the shared M-extension decode
   localparam int MUL_DIV_BIT = 2;
endpackage

// File: rtl/mul_operand_cond.sv
// mul_operand_cond: turns raw operands into unsigned magnitudes plus a result-negate flag.
module mul_operand_cond
   import mul_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MUL_CTRL   = 3
) (
   input  logic [DATA_WIDTH-1:0] op1_i,
   input  logic [DATA_WIDTH-1:0] op2_i,
   input  logic [MUL_CTRL-1:0]   ctrl_i,
   output logic [DATA_WIDTH-1:0] ma_o,
   output logic [DATA_WIDTH-1:0] mb_o,
   output logic                  neg_o
);
   logic sa, sb;
   always_comb begin
      sa    = op1_i[DATA_WIDTH-1] & (ctrl_i == MUL_OP_MULH || ctrl_i == MUL_OP_MULHSU);
      sb    = op2_i[DATA_WIDTH-1] & (ctrl_i == MUL_OP_MULH);
      ma_o  = sa ? -op1_i : op1_i;
      mb_o  = sb ? -op2_i : op2_i;
      neg_o = sa ^ sb;
   end
endmodule

// File: rtl/mul_seq.sv
// mul_seq: fixed-latency radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU
// with a start/busy/done handshake for the hazard unit.
module mul_seq
   import mul_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MUL_CTRL   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] op1,
   input  logic [DATA_WIDTH-1:0] op2,
   input  logic [MUL_CTRL-1:0]   ctrl,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o
);
   localparam int CW = $clog2(DATA_WIDTH);
   localparam int PW = 2 * DATA_WIDTH;

   mul_state_t            state_q;
   logic [CW-1:0]         cnt_q;
   logic [DATA_WIDTH-1:0] ma_q, mb_q, ma_d, mb_d, res_d, result_q;
   logic [PW-1:0]         acc_q, acc_d, prod_d;
   logic                  neg_q, neg_d, busy_q, done_q;
   logic [MUL_CTRL-1:0]   ctrl_q;

   mul_operand_cond #(.DATA_WIDTH(DATA_WIDTH), .MUL_CTRL(MUL_CTRL)) u_cond (
      .op1_i (op1),
      .op2_i (op2),
      .ctrl_i(ctrl),
      .ma_o  (ma_d),
      .mb_o  (mb_d),
      .neg_o (neg_d)
   );

   always_comb begin
      acc_d  = mb_q[0] ? acc_q + ({{DATA_WIDTH{1'b0}}, ma_q} << cnt_q) : acc_q;
      prod_d = neg_q ? -acc_q : acc_q;
      res_d  = ctrl_q[MUL_DIV_BIT] ? '0 :
               ctrl_q == MUL_OP_MUL ? prod_d[DATA_WIDTH-1:0] : prod_d[PW-1:DATA_WIDTH];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ma_q     <= '0;
         mb_q     <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         ctrl_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start_i && !flush_i) begin
               state_q <= CALC;
               busy_q  <= 1'b1;
               ma_q    <= ma_d;
               mb_q    <= mb_d;
               neg_q   <= neg_d;
               ctrl_q  <= ctrl;
               cnt_q   <= '0;
               acc_q   <= '0;
            end
            CALC: if (flush_i) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end else begin
               acc_q <= acc_d;
               mb_q  <= mb_q >> 1;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(DATA_WIDTH - 1)) state_q <= FIX;
            end
            FIX: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               if (!flush_i) begin
                  result_q <= res_d;
                  done_q   <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed and randomized checks of mul_seq latency, handshake and results.
module tb_mul_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic [2:0]  ctrl = '0;
   logic        busy_o, done_o;
   logic [31:0] result_o;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          bc = 0;
   logic        seen_done;

   mul_seq dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .flush_i (flush_i),
      .op1     (op1),
      .op2     (op2),
      .ctrl    (ctrl),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .result_o(result_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // cycle 0 is the cycle start_i is high; cyc is 1 right after the sampling edge
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
      start_i = 1'b1;
      op1 = a;
      op2 = b;
      ctrl = c;
      tick();
      start_i = 1'b0;
      cyc = 1;
      bc = 0;
   endtask

   task automatic wait_done();
      while (!done_o && cyc < 60) begin
         bc += int'(busy_o);
         tick();
      end
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] c, input logic [31:0] exp);
      launch(a, b, c);
      wait_done();
      chk({tag, "_lat"}, 64'(cyc), 64'd34);
      chk(tag, {32'b0, result_o}, {32'b0, exp});
   endtask

   function automatic logic [31:0] gold(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
      logic [63:0] ea, eb, p;
      ea = (c == 3'b001 || c == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (c == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return c[2] ? 32'b0 : (c == 3'b000) ? p[31:0] : p[63:32];
   endfunction

   initial begin
      #12;
      chk("reset_busy", {63'b0, busy_o}, 64'd0);
      chk("reset_done", {63'b0, done_o}, 64'd0);
      chk("reset_result", {32'b0, result_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      // basic MUL with latency and busy-width checks
      launch(32'd7, 32'd6, 3'b000);
      wait_done();
      chk("mul_lat", 64'(cyc), 64'd34);
      chk("mul_busy_cycles", 64'(bc), 64'd33);
      chk("mul_done_busy", {63'b0, busy_o}, 64'd0);
      chk("mul_7x6", {32'b0, result_o}, 64'h2A);
      tick();
      chk("done_pulse", {63'b0, done_o}, 64'd0);
      chk("result_hold", {32'b0, result_o}, 64'h2A);
      run("mulh_minmin", 32'h80000000, 32'h80000000, 3'b001, 32'h40000000);
      run("mulh_neg1x2", 32'hFFFFFFFF, 32'h00000002, 3'b001, 32'hFFFFFFFF);
      run("mulhsu_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010, 32'hFFFFFFFF);
      run("mulhu_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32'hFFFFFFFE);
      run("mul_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 32'h00000001);
      run("div_ctrl_zero", 32'd7, 32'd6, 3'b100, 32'h0);
      // start re-pulsed while busy is ignored
      launch(32'd7, 32'd6, 3'b000);
      while (cyc < 5) tick();
      start_i = 1'b1;
      op1 = 32'd100;
      op2 = 32'd100;
      tick();
      start_i = 1'b0;
      wait_done();
      chk("repulse_lat", 64'(cyc), 64'd34);
      chk("repulse_result", {32'b0, result_o}, 64'h2A);
      // start in the done cycle is accepted
      launch(32'd3, 32'd5, 3'b000);
      wait_done();
      chk("b2b_lat", 64'(cyc), 64'd34);
      chk("b2b_result", {32'b0, result_o}, 64'd15);
      tick();
      // flush mid-op aborts without done
      launch(32'd9, 32'd9, 3'b000);
      while (cyc < 10) tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush_busy", {63'b0, busy_o}, 64'd0);
      seen_done = 1'b0;
      repeat (40) begin
         seen_done |= done_o;
         tick();
      end
      chk("flush_no_done", {63'b0, seen_done}, 64'd0);
      chk("flush_hold", {32'b0, result_o}, 64'd15);
      run("zero_op", 32'd0, 32'd12345, 3'b000, 32'd0);
      // flush in IDLE overrides start
      start_i = 1'b1;
      flush_i = 1'b1;
      tick();
      start_i = 1'b0;
      flush_i = 1'b0;
      chk("idle_flush_start", {63'b0, busy_o}, 64'd0);
      for (int i = 0; i < 200; i++) begin
         logic [31:0] a, b;
         logic [2:0] c;
         a = $urandom;
         b = $urandom;
         c = 3'($urandom_range(0, 4));
         if (i < 4) a = 32'h80000000;
         run($sformatf("rand%0d", i), a, b, c, gold(a, b, c));
      end
      // async reset in the middle of an op
      run("pre_reset", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 32'h1);
      launch(32'd11, 32'd13, 3'b001);
      while (cyc < 20) tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {63'b0, busy_o}, 64'd0);
      chk("arst_done", {63'b0, done_o}, 64'd0);
      chk("arst_result", {32'b0, result_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      run("post_reset", 32'd11, 32'd13, 3'b000, 32'd143);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
